mm_bram_parallel_ctrl: RTL and testbench

Sequencer for the parallel BRAM matrix-multiply datapath. On `start` it streams every row address of the source SRAM, aligns `dpath_sum_en`/`dpath_result_wraddr` to the SRAM read latency, and counts result write-backs from the datapath. It pulses `done` once all `ROW_NUM` result rows have been written. It sits between the top-level job interface and the source SRAM / datapath pair.

---
 rtl/mm_bram_parallel_ctrl.sv | 146 ++++++++++++++
 tb/tb_mm_bram_parallel_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_bram_parallel_ctrl.sv
// Job sequencer for the parallel BRAM matrix-multiply datapath: issues source-row reads,
// aligns the datapath strobe to the SRAM read latency and counts result write-backs.
module mm_bram_parallel_ctrl #(
    parameter int unsigned ROW_NUM        = 32,
    parameter int unsigned SRAM_LAT       = 1,
    localparam int unsigned ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1,
    localparam int unsigned CNT_WIDTH      = ROW_ADDR_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      hold,
    output logic                      src_rd_en,
    output logic [ROW_ADDR_WIDTH-1:0] src_rdaddr,
    output logic                      dpath_sum_en,
    output logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr,
    input  logic                      wb_val,
    output logic                      busy,
    output logic                      done,
    output logic                      wb_err
);
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ADDR = ROW_ADDR_WIDTH'(ROW_NUM - 1);
    localparam logic [CNT_WIDTH-1:0]      WB_TARGET = CNT_WIDTH'(ROW_NUM);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic                      en;
        logic [ROW_ADDR_WIDTH-1:0] addr;
    } stage_t;

    state_t                    state, state_next;
    logic [ROW_ADDR_WIDTH-1:0] issue_cnt, issue_cnt_next;
    logic [CNT_WIDTH-1:0]      wb_cnt, wb_cnt_next;
    logic                      src_rd_en_next;
    logic [ROW_ADDR_WIDTH-1:0] src_rdaddr_next;
    logic                      busy_next, done_next, wb_err_next;
    logic                      active;
    stage_t [SRAM_LAT-1:0]     pipe;
    stage_t                    stage_in;

    // Next-state, counters and registered-output values
    always_comb begin
        state_next      = state;
        issue_cnt_next  = issue_cnt;
        wb_cnt_next     = wb_cnt;
        src_rd_en_next  = 1'b0;
        src_rdaddr_next = src_rdaddr;
        wb_err_next     = wb_err;
        active          = (state == ISSUE) || (state == DRAIN);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = ISSUE;
                    issue_cnt_next = '0;
                    wb_cnt_next    = '0;
                    wb_err_next    = 1'b0;
                end
            end
            ISSUE: begin
                if (!hold) begin
                    src_rd_en_next  = 1'b1;
                    src_rdaddr_next = issue_cnt;
                    if (issue_cnt == LAST_ADDR) begin
                        state_next = DRAIN;
                    end else begin
                        issue_cnt_next = issue_cnt + ROW_ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                state_next = DRAIN;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A write-back outside a job, or beyond the row count, is flagged and not counted
        if (wb_val) begin
            if (active && (wb_cnt < WB_TARGET)) begin
                wb_cnt_next = wb_cnt + CNT_WIDTH'(1);
            end else begin
                wb_err_next = 1'b1;
            end
        end

        if (active && (wb_cnt_next == WB_TARGET)) begin
            state_next = DONE;
        end

        busy_next = active && (state_next != DONE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            wb_cnt     <= '0;
            src_rd_en  <= 1'b0;
            src_rdaddr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            state      <= state_next;
            issue_cnt  <= issue_cnt_next;
            wb_cnt     <= wb_cnt_next;
            src_rd_en  <= src_rd_en_next;
            src_rdaddr <= src_rdaddr_next;
            busy       <= busy_next;
            done       <= done_next;
            wb_err     <= wb_err_next;
        end
    end

    // Read-latency alignment: the strobe and row address leave SRAM_LAT cycles after issue
    assign stage_in = '{en: src_rd_en, addr: src_rdaddr};

    if (SRAM_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pipe <= '0;
            end else begin
                pipe <= stage_in;
            end
        end
    end else begin : g_latn
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pipe <= '0;
            end else begin
                pipe <= {pipe[SRAM_LAT-2:0], stage_in};
            end
        end
    end

    assign dpath_sum_en        = pipe[SRAM_LAT-1].en;
    assign dpath_result_wraddr = pipe[SRAM_LAT-1].addr;

endmodule

// File: tb/tb_mm_bram_parallel_ctrl.sv
// Scoreboard bench for mm_bram_parallel_ctrl: three instances (4 rows/lat 1, 5 rows/lat 2,
// 1 row/lat 1), each fed by a fixed-latency datapath model.
module tb_mm_bram_parallel_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_v    [3];
    logic start_v  [3];
    logic hold_v   [3];
    logic inj_v    [3];
    logic rd_en_v  [3];
    logic sum_en_v [3];
    logic wb_v     [3];
    logic busy_v   [3];
    logic done_v   [3];
    logic err_v    [3];
    logic [2:0] dly [3];

    logic [1:0] rd_a0, sum_a0;
    logic [2:0] rd_a1, sum_a1;
    logic [0:0] rd_a2, sum_a2;
    int rd_a  [3];
    int sum_a [3];

    int n_chk  = 0;
    int n_fail = 0;
    int q [9][$];
    string kname [3] = '{"rd", "sum", "done"};

    mm_bram_parallel_ctrl #(.ROW_NUM(4), .SRAM_LAT(1)) u0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .hold(hold_v[0]),
        .src_rd_en(rd_en_v[0]), .src_rdaddr(rd_a0),
        .dpath_sum_en(sum_en_v[0]), .dpath_result_wraddr(sum_a0),
        .wb_val(wb_v[0]), .busy(busy_v[0]), .done(done_v[0]), .wb_err(err_v[0]));

    mm_bram_parallel_ctrl #(.ROW_NUM(5), .SRAM_LAT(2)) u1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .hold(hold_v[1]),
        .src_rd_en(rd_en_v[1]), .src_rdaddr(rd_a1),
        .dpath_sum_en(sum_en_v[1]), .dpath_result_wraddr(sum_a1),
        .wb_val(wb_v[1]), .busy(busy_v[1]), .done(done_v[1]), .wb_err(err_v[1]));

    mm_bram_parallel_ctrl #(.ROW_NUM(1), .SRAM_LAT(1)) u2 (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .hold(hold_v[2]),
        .src_rd_en(rd_en_v[2]), .src_rdaddr(rd_a2),
        .dpath_sum_en(sum_en_v[2]), .dpath_result_wraddr(sum_a2),
        .wb_val(wb_v[2]), .busy(busy_v[2]), .done(done_v[2]), .wb_err(err_v[2]));

    always_comb begin
        rd_a[0]  = int'(rd_a0);
        rd_a[1]  = int'(rd_a1);
        rd_a[2]  = int'(rd_a2);
        sum_a[0] = int'(sum_a0);
        sum_a[1] = int'(sum_a1);
        sum_a[2] = int'(sum_a2);
        for (int i = 0; i < 3; i++) wb_v[i] = dly[i][2] | inj_v[i];
    end

    // Datapath model: one write-back three cycles after each dpath_sum_en
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            dly[i] <= rst_v[i] ? 3'b000 : {dly[i][1:0], sum_en_v[i]};
        end
    end

    function automatic void chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endfunction

    function automatic void pop_chk(input int i, input int k, input int got);
        string nm = $sformatf("u%0d_%s", i, kname[k]);
        if (q[i*3+k].size() == 0) chk({nm, "_unexpected"}, got, -1);
        else chk(nm, got, q[i*3+k].pop_front());
    endfunction

    // Expected events: rd/sum encoded as cycle*256+addr, done as cycle*2+wb_err
    function automatic void push_job(input int i, input int s, input int n, input int lat,
                                     input int gap_at, input int gap_len);
        int t = 0;
        for (int k = 0; k < n; k++) begin
            t = s + 1 + k + ((k >= gap_at) ? gap_len : 0);
            q[i*3].push_back(t * 256 + k);
            q[i*3+1].push_back((t + lat) * 256 + k);
        end
        q[i*3+2].push_back((t + lat + 4) * 2);
    endfunction

    function automatic void qempty(input int i);
        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d_%s_left", i, kname[k]), q[i*3+k].size(), 0);
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_v[i]) begin
                    if (rd_en_v[i])  pop_chk(i, 0, cyc * 256 + rd_a[i]);
                    if (sum_en_v[i]) pop_chk(i, 1, cyc * 256 + sum_a[i]);
                    if (done_v[i])   pop_chk(i, 2, cyc * 2 + int'(err_v[i]));
                end
            end
        end
    endtask

    task automatic start_job(input int i);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    int s;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
            hold_v[i]  = 1'b0;
            inj_v[i]   = 1'b0;
        end
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_rst_rd_en", i), int'(rd_en_v[i]), 0);
            chk($sformatf("u%0d_rst_sum_en", i), int'(sum_en_v[i]), 0);
            chk($sformatf("u%0d_rst_busy", i), int'(busy_v[i]), 0);
            chk($sformatf("u%0d_rst_done", i), int'(done_v[i]), 0);
            chk($sformatf("u%0d_rst_err", i), int'(err_v[i]), 0);
            chk($sformatf("u%0d_rst_rdaddr", i), rd_a[i], 0);
            chk($sformatf("u%0d_rst_wraddr", i), sum_a[i], 0);
        end
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        repeat (2) @(negedge clk);

        // Plain 4-row job
        s = cyc + 1;
        push_job(0, s, 4, 1, 0, 0);
        start_job(0);
        chk("u0_busy_at_start", int'(busy_v[0]), 0);
        @(negedge clk);
        chk("u0_busy_first_rd", int'(busy_v[0]), 1);
        repeat (7) @(negedge clk);
        chk("u0_busy_pre_done", int'(busy_v[0]), 1);
        @(negedge clk);
        chk("u0_busy_in_done", int'(busy_v[0]), 0);
        repeat (4) @(negedge clk);
        chk("u0_err_clean", int'(err_v[0]), 0);
        qempty(0);

        // Hold sampled at the 2nd and 3rd edges after start
        s = cyc + 1;
        push_job(0, s, 4, 1, 1, 2);
        start_job(0);
        @(negedge clk);
        hold_v[0] = 1'b1;
        @(negedge clk);
        chk("u0_hold_rd_en", int'(rd_en_v[0]), 0);
        chk("u0_hold_addr", rd_a[0], 0);
        @(negedge clk);
        hold_v[0] = 1'b0;
        repeat (12) @(negedge clk);
        qempty(0);

        // 5 rows, 2-cycle SRAM latency
        s = cyc + 1;
        push_job(1, s, 5, 2, 0, 0);
        start_job(1);
        repeat (15) @(negedge clk);
        qempty(1);

        // Reset mid-pipe after the 2nd issue
        s = cyc + 1;
        q[0].push_back((s + 1) * 256 + 0);
        q[0].push_back((s + 2) * 256 + 1);
        q[1].push_back((s + 2) * 256 + 0);
        start_job(0);
        repeat (2) @(negedge clk);
        #2 rst_v[0] = 1'b1;
        #1;
        chk("u0_abort_rd_en", int'(rd_en_v[0]), 0);
        chk("u0_abort_rdaddr", rd_a[0], 0);
        chk("u0_abort_sum_en", int'(sum_en_v[0]), 0);
        chk("u0_abort_wraddr", sum_a[0], 0);
        chk("u0_abort_busy", int'(busy_v[0]), 0);
        @(negedge clk);
        #2 rst_v[0] = 1'b0;
        @(negedge clk);
        qempty(0);
        s = cyc + 1;
        push_job(0, s, 4, 1, 0, 0);
        start_job(0);
        repeat (12) @(negedge clk);
        qempty(0);

        // Stray write-backs, ignored start pulses
        inj_v[0] = 1'b1;
        @(negedge clk);
        inj_v[0] = 1'b0;
        chk("u0_err_idle_wb", int'(err_v[0]), 1);
        repeat (3) @(negedge clk);
        chk("u0_err_sticky", int'(err_v[0]), 1);
        s = cyc + 1;
        push_job(0, s, 4, 1, 0, 0);
        start_job(0);
        chk("u0_err_cleared", int'(err_v[0]), 0);
        @(negedge clk);
        start_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        start_v[0] = 1'b0;
        repeat (6) @(negedge clk);
        inj_v[0] = 1'b1;
        @(negedge clk);
        inj_v[0] = 1'b0;
        chk("u0_err_fifth_wb", int'(err_v[0]), 1);
        repeat (5) @(negedge clk);
        chk("u0_err_fifth_sticky", int'(err_v[0]), 1);
        qempty(0);

        // Single-row jobs back to back with start held high
        s = cyc + 1;
        for (int j = 0; j < 3; j++) push_job(2, s + 8 * j, 1, 1, 0, 0);
        start_v[2] = 1'b1;
        repeat (17) @(negedge clk);
        start_v[2] = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 3; i++) qempty(i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
